// File: rtl/sign_mag_to_bcd_pkg.sv
// Shared constants and FSM state type for the signed-magnitude to BCD converter.
package sign_mag_to_bcd_pkg;

    localparam int MAG_W      = 15;
    localparam int NUM_DIGITS = 5;
    localparam int BCD_W      = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sign_mag_to_bcd_if.sv
// Request/result bundle between the adder stage (master) and the BCD converter (slave).
interface sign_mag_to_bcd_if #(
    parameter int MAG_W      = sign_mag_to_bcd_pkg::MAG_W,
    parameter int NUM_DIGITS = sign_mag_to_bcd_pkg::NUM_DIGITS
);
    logic                    start;
    logic [MAG_W:0]          value;
    logic [4*NUM_DIGITS-1:0] bcd;
    logic                    neg;
    logic                    busy;
    logic                    finish;

    modport master (output start, value, input bcd, neg, busy, finish);
    modport slave  (input start, value, output bcd, neg, busy, finish);
endinterface

// File: rtl/sign_mag_to_bcd_digit_adj.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_digit_adj (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);
    assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;
endmodule

// File: rtl/sign_mag_to_bcd.sv
// Sequential double-dabble converter: signed-magnitude word in, BCD digits plus sign out.
import sign_mag_to_bcd_pkg::*;

module sign_mag_to_bcd #(
    parameter int MAG_W      = sign_mag_to_bcd_pkg::MAG_W,
    parameter int NUM_DIGITS = sign_mag_to_bcd_pkg::NUM_DIGITS
) (
    input  logic             clk,
    input  logic             RST,
    sign_mag_to_bcd_if.slave io
);
    localparam int W_BCD = 4 * NUM_DIGITS;
    localparam int SR_W  = W_BCD + MAG_W;
    localparam int CNT_W = $clog2(MAG_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAG_W - 1);

    state_t             r_state, w_next;
    logic               w_busy;
    logic [SR_W-1:0]    r_shift;
    logic [SR_W-1:0]    w_adj;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sign;
    logic               r_neg;
    logic               r_finish;
    logic [W_BCD-1:0]   r_bcd;

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
            bcd_digit_adj u_adj (
                .i_digit (r_shift[MAG_W+4*g +: 4]),
                .o_digit (w_adj[MAG_W+4*g +: 4])
            );
        end
    endgenerate

    assign w_adj[MAG_W-1:0] = r_shift[MAG_W-1:0];

    always_ff @(posedge clk) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        case (r_state)
            IDLE:  if (io.start) w_next = LOAD;
            LOAD:  begin
                w_busy = 1'b1;
                w_next = SHIFT;
            end
            SHIFT: begin
                w_busy = 1'b1;
                if (r_cnt == LAST_CNT) w_next = DONE;
            end
            // Leave only after finish has been shown for at least one cycle.
            DONE:  if (r_finish && !io.start) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_shift  <= '0;
            r_cnt    <= '0;
            r_sign   <= 1'b0;
            r_neg    <= 1'b0;
            r_finish <= 1'b0;
            r_bcd    <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    r_shift <= {{W_BCD{1'b0}}, io.value[MAG_W-1:0]};
                    // Negative zero reports as positive.
                    r_sign  <= io.value[MAG_W] & (|io.value[MAG_W-1:0]);
                    r_cnt   <= '0;
                end
                SHIFT: begin
                    r_shift <= {w_adj[SR_W-2:0], 1'b0};
                    r_cnt   <= r_cnt + 1'b1;
                end
                DONE: begin
                    if (!r_finish) begin
                        r_finish <= 1'b1;
                        r_bcd    <= r_shift[SR_W-1:MAG_W];
                        r_neg    <= r_sign;
                    end else if (!io.start) begin
                        r_finish <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io.bcd    = r_bcd;
    assign io.neg    = r_neg;
    assign io.busy   = w_busy;
    assign io.finish = r_finish;

endmodule

// File: tb/tb_sign_mag_to_bcd.sv
// Scoreboard bench for sign_mag_to_bcd: latency, results, handshake and reset abort.
module tb_sign_mag_to_bcd;

    logic clk = 1'b0;
    logic RST;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    logic [20:0] sb_q[$];

    sign_mag_to_bcd_if u_if ();

    sign_mag_to_bcd dut (
        .clk (clk),
        .RST (RST),
        .io  (u_if)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] model(input logic [15:0] v);
        int          m;
        logic [19:0] b;
        m = int'(v[14:0]);
        b = '0;
        for (int d = 0; d < 5; d++) begin
            b[4*d +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return {(v[15] && v[14:0] != 15'd0), b};
    endfunction

    task automatic convert(input logic [15:0] v, input bit pulse, input bit scramble, input string name);
        int          lat;
        logic [20:0] exp;
        logic [20:0] got;
        @(negedge clk);
        u_if.value = v;
        u_if.start = 1'b1;
        sb_q.push_back(model(v));
        @(posedge clk);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (pulse) u_if.start = 1'b0;
            if (scramble && n >= 2) u_if.value = 16'($urandom);
            @(posedge clk);
            #1;
            if (n == 5) begin
                total_cnt++;
                if (u_if.busy !== 1'b1) $display("FAIL %s busy: got %b want 1", name, u_if.busy);
                else pass_cnt++;
            end
            if (u_if.finish === 1'b1) begin
                lat = n;
                break;
            end
        end
        total_cnt++;
        if (lat !== 17) $display("FAIL %s latency: got %0d want 17", name, lat);
        else pass_cnt++;
        exp = sb_q.pop_front();
        got = {u_if.neg, u_if.bcd};
        total_cnt++;
        if (got !== exp) $display("FAIL %s result: got neg=%b bcd=%h want neg=%b bcd=%h",
                                  name, got[20], got[19:0], exp[20], exp[19:0]);
        else pass_cnt++;
    endtask

    task automatic release_start(input string name);
        @(negedge clk);
        u_if.start = 1'b0;
        @(posedge clk);
        #1;
        total_cnt++;
        if (u_if.finish !== 1'b0 || u_if.busy !== 1'b0)
            $display("FAIL %s release: got finish=%b busy=%b want 0/0", name, u_if.finish, u_if.busy);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        RST        = 1'b1;
        u_if.start = 1'b0;
        u_if.value = '0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if ({u_if.bcd, u_if.neg, u_if.finish, u_if.busy} !== 23'd0)
            $display("FAIL reset_state: got bcd=%h neg=%b finish=%b busy=%b want all 0",
                     u_if.bcd, u_if.neg, u_if.finish, u_if.busy);
        else pass_cnt++;
        @(negedge clk);
        RST = 1'b0;
    endtask

    task automatic test_values();
        logic [15:0] vals[6] = '{16'h3039, 16'hFFFF, 16'h8001, 16'h8000, 16'h0000, 16'h7FFF};
        for (int i = 0; i < 6; i++) begin
            convert(vals[i], 1'b0, 1'b0, $sformatf("value_%h", vals[i]));
            release_start($sformatf("value_%h", vals[i]));
        end
    endtask

    task automatic test_hold();
        convert(16'h0123, 1'b0, 1'b0, "hold");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total_cnt++;
            if (u_if.finish !== 1'b1 || u_if.bcd !== 20'h00291)
                $display("FAIL hold_cycle%0d: got finish=%b bcd=%h want 1 bcd=00291", i, u_if.finish, u_if.bcd);
            else pass_cnt++;
        end
        release_start("hold");
    endtask

    task automatic test_pulse();
        convert(16'h84D2, 1'b1, 1'b0, "pulse");
        @(posedge clk);
        #1;
        total_cnt++;
        if (u_if.finish !== 1'b0) $display("FAIL pulse_width: got finish=%b want 0", u_if.finish);
        else pass_cnt++;
    endtask

    task automatic test_rst_mid();
        int highs;
        @(negedge clk);
        u_if.value = 16'h1234;
        u_if.start = 1'b1;
        @(posedge clk);
        repeat (8) @(posedge clk);
        @(negedge clk);
        RST = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if ({u_if.bcd, u_if.neg, u_if.finish, u_if.busy} !== 23'd0)
            $display("FAIL rst_mid_outputs: got bcd=%h neg=%b finish=%b busy=%b want all 0",
                     u_if.bcd, u_if.neg, u_if.finish, u_if.busy);
        else pass_cnt++;
        @(negedge clk);
        RST        = 1'b0;
        u_if.start = 1'b0;
        highs = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (u_if.finish !== 1'b0 || u_if.busy !== 1'b0) highs++;
        end
        total_cnt++;
        if (highs !== 0) $display("FAIL rst_mid_abort: got %0d active cycles want 0", highs);
        else pass_cnt++;
        convert(16'h0007, 1'b0, 1'b0, "after_rst");
        release_start("after_rst");
    endtask

    task automatic test_back_to_back();
        convert(16'd9999, 1'b0, 1'b1, "b2b_9999");
        release_start("b2b_9999");
        convert(16'd10000, 1'b0, 1'b1, "b2b_10000");
        release_start("b2b_10000");
    endtask

    initial begin
        test_reset();
        test_values();
        test_hold();
        test_pulse();
        test_rst_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sign_mag_to_bcd.md
SIGN_MAG_TO_BCD -- requirements
Module: sign_mag_to_bcd

Interface
REQ-001 Parameter MAG_W, default 15, magnitude width of the signed-magnitude input.
REQ-002 Parameter NUM_DIGITS, default 5, number of BCD output digits (32767 max).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  level request; conversion begins when sampled high in IDLE.
REQ-006 value  input  16  signed-magnitude operand: bit 15 sign, bits 14:0 magnitude (the adder stage's result word).
REQ-007 bcd  output  20  result digits, digit 4 in bits 19:16 down to digit 0 in bits 3:0.
REQ-008 neg  output  1  result sign for display minus indicator.
REQ-009 busy  output  1  high in LOAD and SHIFT states.
REQ-010 finish  output  1  registered done flag, same handshake as the adder stage.

Function
REQ-011 FSM states SHALL be IDLE, LOAD, SHIFT, DONE; only these four are reachable.
REQ-012 IDLE: start=1 SHALL move to LOAD; start=0 SHALL stay in IDLE.
REQ-013 LOAD: value SHALL be captured into a 35-bit shift register (20-bit BCD field zeroed, magnitude in low 15 bits), sign captured, iteration counter cleared; next state SHIFT.
REQ-014 SHIFT: each cycle every BCD digit >=5 SHALL get +3, then the whole register shifts left by one; counter increments.
REQ-015 SHIFT SHALL last exactly MAG_W (15) cycles; on the 15th cycle next state is DONE.
REQ-016 On entry to DONE, bcd and neg SHALL be loaded from the shift register and captured sign in the same edge finish goes high.
REQ-017 finish SHALL rise exactly 17 rising edges after the edge that samples start in IDLE (1 LOAD + 15 SHIFT + 1 DONE).
REQ-018 DONE: finish SHALL stay high while start=1; start=0 SHALL move to IDLE and clear finish on that edge.
REQ-019 start deasserting during LOAD/SHIFT SHALL be ignored; conversion completes, finish asserts for at least one cycle.
REQ-020 value changes after LOAD SHALL NOT affect the current result.
REQ-021 bcd and neg SHALL hold the last result until the next DONE entry.
REQ-022 Negative zero (value=16'h8000) SHALL report bcd=0, neg=0.
REQ-023 Every output digit SHALL be in 0..9; digit 4 SHALL never exceed 3.

Reset
REQ-024 RST=1 at a rising edge SHALL force state IDLE, bcd=0, neg=0, finish=0, busy=0, counter and shift register 0.
REQ-025 RST asserted mid-conversion SHALL abort it; no finish pulse for the aborted request.
REQ-026 After RST release, a new conversion SHALL require start sampled high in IDLE.

Structure
REQ-027 State enum, MAG_W, NUM_DIGITS and the 20-bit BCD width SHALL live in a shared calc package.
REQ-028 Per-digit add-3 correction SHALL be one combinational sub-module, bcd_digit_adj (4-bit in, 4-bit out), instantiated NUM_DIGITS times via generate.

Verification
REQ-029 value=16'h3039 (12345), start held -> finish after 17 edges, bcd=20'h12345, neg=0.
REQ-030 value=16'hFFFF -> bcd=20'h32767, neg=1; value=16'h8001 -> bcd=20'h00001, neg=1.
REQ-031 value=16'h8000 and 16'h0000 -> bcd=0, neg=0 in both cases.
REQ-032 start held 5 cycles past finish -> finish stays 1; start low -> IDLE next edge, finish=0; start pulsed 1 cycle -> full conversion, finish high 1 cycle.
REQ-033 RST at SHIFT cycle 7 -> all outputs 0 next edge; no finish; then 16'h0007 -> bcd=20'h00007.
REQ-034 Back-to-back 9999 then 10000 with value changed during SHIFT -> results 20'h09999 then 20'h10000, each unaffected by mid-conversion value changes.
